// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared state encoding and default sizing for serial_addsub16
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DIGIT = 4;

endpackage

// File: rtl/digit_adder.sv
// rtl/digit_adder.sv - DIGIT-bit ripple-carry adder slice with carry in/out
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic c;

    always_comb begin
        c   = cin;
        sum = '0;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/serial_addsub16.sv
// rtl/serial_addsub16.sv - digit-serial add/subtract unit; optional ovf output via ADDSUB_OVF_EN
module serial_addsub16
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    state_t          state, next_state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] a_q, b_q;
    logic            carry;
    logic [DIGIT-1:0] d_sum;
    logic            d_cout;
    logic            last;

    // Operands shift right each RUN cycle so the live slice is always in the low digit.
    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (carry),
        .sum  (d_sum),
        .cout (d_cout)
    );

    assign last  = (cnt == CW'(STEPS - 1));
    assign ready = (state == IDLE);
    assign busy  = (state == RUN);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
`ifdef ADDSUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            state <= next_state;
            done  <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b ^ {WIDTH{sub}};
                        carry <= cin ^ sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_q                  <= a_q >> DIGIT;
                    b_q                  <= b_q >> DIGIT;
                    carry                <= d_cout;
                    s[cnt*DIGIT +: DIGIT] <= d_sum;
                    cnt                  <= cnt + 1'b1;
                    if (last) begin
                        cout <= d_cout;
`ifdef ADDSUB_OVF_EN
                        // Carry into the MSB is recovered from the MSB sum bit and its operands.
                        ovf  <= a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ d_sum[DIGIT-1] ^ d_cout;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
